pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/DM, DM/WB registers).
- Detects load-use hazards and taken branches, and freezes the pipe while a data-memory access waits for ready.
- Drives per-register enable and flush/bubble controls, holds a post-reset pipe-clearing window, and counts stall cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for a 5-stage pipeline. It handles
//             load-use hazards, taken branches, data-memory waits with a
//             timeout, and a pipe-clearing window after reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        dm_req,
  input  logic        dm_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_dm_en,
  output logic        dm_wb_en,
  output logic        dm_wb_bubble,
  output logic        mem_timeout_err,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  localparam logic [3:0]  C_HOLD_INIT = 4'(RESET_CYCLES);
  localparam logic [7:0]  C_TIMEOUT   = 8'(MEM_TIMEOUT);
  localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic w_mem_stall;
  logic w_load_use;
  logic w_run_eval;
  logic w_freeze;

  assign w_mem_stall = dm_req & ~dm_ready;
  assign w_load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= C_HOLD_INIT;
      wait_cnt_q    <= 8'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    stall_count_d   = stall_count_q;
    w_run_eval      = 1'b0;
    w_freeze        = 1'b0;
    pc_en           = 1'b0;
    if_id_en        = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_en        = 1'b0;
    id_ex_flush     = 1'b0;
    ex_dm_en        = 1'b0;
    dm_wb_en        = 1'b0;
    dm_wb_bubble    = 1'b0;
    mem_timeout_err = 1'b0;

    case (state_q)
      S_HOLD: begin
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_dm_en     = 1'b1;
        dm_wb_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        dm_wb_bubble = 1'b1;
        hold_cnt_d   = hold_cnt_q - 4'd1;
        if (hold_cnt_q == 4'd1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (w_mem_stall) begin
          w_freeze   = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // dm_req is not consulted here: only dm_ready ends the wait.
        if (dm_ready) begin
          w_run_eval = 1'b1;
          state_d    = S_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          w_freeze   = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == C_TIMEOUT) begin
            state_d = S_ERROR;
          end
        end
      end
      default: begin
        mem_timeout_err = 1'b1;
      end
    endcase

    if (w_freeze) begin
      dm_wb_en     = 1'b1;
      dm_wb_bubble = 1'b1;
    end

    if (w_run_eval) begin
      pc_en    = 1'b1;
      if_id_en = 1'b1;
      id_ex_en = 1'b1;
      ex_dm_en = 1'b1;
      dm_wb_en = 1'b1;
      // A taken branch squashes the consumer, so a same-cycle load-use is moot.
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_en &&
        (stall_count_q != C_COUNT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;

endmodule

`default_nettype wire
